// File: rtl/mem_pager_pkg.sv
// Shared constants for the banked-memory pager: register offsets, page width
// and the CPU address bits that pick one of the four 16KB windows.
package mem_pager_pkg;

  localparam int PAGE_W  = 4;
  localparam int NUM_WIN = 4;

  localparam logic [7:0] PG0      = 8'd0;
  localparam logic [7:0] PG1      = 8'd1;
  localparam logic [7:0] PG2      = 8'd2;
  localparam logic [7:0] PG3      = 8'd3;
  localparam logic [7:0] CTRL     = 8'd4;
  localparam logic [7:0] PROT     = 8'd5;
  localparam logic [7:0] NUM_REGS = 8'd6;

  localparam int WIN_HI = 15;
  localparam int WIN_LO = 14;

  typedef logic [PAGE_W-1:0] page_t;

endpackage

// File: rtl/mem_pager_strobe_sync.sv
// Synchronises an active-low CPU strobe into the local clock and emits one
// clock pulse per debounced falling edge; lows shorter than the depth are ignored.
module strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk100,
  input  logic n_reset,
  input  logic strobe_n_i,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic                   fall_q;
  logic                   all_low;
  logic                   all_high;

  assign all_low  = ~|sync_q;
  assign all_high = &sync_q;

  // level_q only flips once the whole chain agrees, so a short low never
  // reaches the edge detector and a long low yields exactly one pulse.
  always_ff @(posedge clk100 or negedge n_reset) begin
    if (!n_reset) begin
      sync_q  <= '1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_n_i};
      fall_q <= level_q & all_low;
      if (all_low)
        level_q <= 1'b0;
      else if (all_high)
        level_q <= 1'b1;
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/mem_pager.sv
// Z80-to-SRAM pager: four 16KB window page registers widen the CPU address to
// 18 bits, with per-window write protect, register read-back and ROM-off latch.
module mem_pager
  import mem_pager_pkg::*;
#(
  parameter logic [7:0] PAGE_BASE   = 8'hF0,
  parameter logic [7:0] ROMOFF_PORT = 8'h38,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk100,
  input  logic        n_reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        n_iorq,
  input  logic        n_mreq,
  input  logic        n_rd,
  input  logic        n_wr,
  output logic [7:0]  reg_dout,
  output logic        n_reg_cs,
  output logic [17:0] sram_addr,
  output logic        n_sram_we,
  output logic        n_rom_active
);

  page_t       page_q [NUM_WIN];
  page_t       page_d [NUM_WIN];
  logic        enable_q, enable_d;
  logic [3:0]  protect_q, protect_d;
  logic        n_rom_active_q, n_rom_active_d;

  logic        wr_evt;
  logic [7:0]  reg_off;
  logic        reg_hit;
  logic [1:0]  win;
  logic [3:0]  unused_dout_hi;

  assign unused_dout_hi = cpu_dout[7:4];

  strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_iowr_sync (
    .clk100     (clk100),
    .n_reset    (n_reset),
    .strobe_n_i (n_iorq | n_wr),
    .fall_o     (wr_evt)
  );

  // Modulo-256 subtraction keeps the range test correct for any base.
  assign reg_off = cpu_addr[7:0] - PAGE_BASE;
  assign reg_hit = (reg_off < NUM_REGS);

  always_comb begin
    page_d         = page_q;
    enable_d       = enable_q;
    protect_d      = protect_q;
    n_rom_active_d = n_rom_active_q;
    if (wr_evt) begin
      if (cpu_addr[7:0] == ROMOFF_PORT)
        n_rom_active_d = 1'b1;
      if (reg_hit) begin
        case (reg_off)
          PG0, PG1, PG2, PG3: page_d[reg_off[1:0]] = cpu_dout[PAGE_W-1:0];
          CTRL:               enable_d = cpu_dout[0];
          PROT:               protect_d = cpu_dout[3:0];
          default:            ;
        endcase
      end
    end
  end

  always_ff @(posedge clk100 or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < NUM_WIN; i++)
        page_q[i] <= page_t'(i);
      enable_q       <= 1'b0;
      protect_q      <= 4'h0;
      n_rom_active_q <= 1'b0;
    end else begin
      page_q         <= page_d;
      enable_q       <= enable_d;
      protect_q      <= protect_d;
      n_rom_active_q <= n_rom_active_d;
    end
  end

  assign n_reg_cs = n_iorq | n_rd | ~reg_hit;

  always_comb begin
    reg_dout = 8'h00;
    if (!n_reg_cs) begin
      case (reg_off)
        PG0, PG1, PG2, PG3: reg_dout = {4'h0, page_q[reg_off[1:0]]};
        CTRL:               reg_dout = {7'b0, enable_q};
        PROT:               reg_dout = {4'h0, protect_q};
        default:            reg_dout = 8'h00;
      endcase
    end
  end

  assign win       = cpu_addr[WIN_HI:WIN_LO];
  assign sram_addr = enable_q ? {page_q[win], cpu_addr[13:0]} : {2'b00, cpu_addr};
  assign n_sram_we = n_mreq | n_wr | (enable_q & protect_q[win]);

  assign n_rom_active = n_rom_active_q;

endmodule

// File: tb/tb_mem_pager.sv
// Directed bench for mem_pager: a vector table of CPU cycles with expected
// outputs, then hand-written sequences for latency, glitches and async reset.
module tb_mem_pager;

  logic        clk100 = 1'b0;
  logic        n_reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        n_iorq, n_mreq, n_rd, n_wr;
  logic [7:0]  reg_dout;
  logic        n_reg_cs;
  logic [17:0] sram_addr;
  logic        n_sram_we;
  logic        n_rom_active;

  int n_checks = 0;
  int n_fail   = 0;

  mem_pager dut (
    .clk100       (clk100),
    .n_reset      (n_reset),
    .cpu_addr     (cpu_addr),
    .cpu_dout     (cpu_dout),
    .n_iorq       (n_iorq),
    .n_mreq       (n_mreq),
    .n_rd         (n_rd),
    .n_wr         (n_wr),
    .reg_dout     (reg_dout),
    .n_reg_cs     (n_reg_cs),
    .sram_addr    (sram_addr),
    .n_sram_we    (n_sram_we),
    .n_rom_active (n_rom_active)
  );

  always #5 clk100 = ~clk100;

  typedef enum logic [1:0] {IOW, IORD, MEMRD, MEMWR} kind_e;

  typedef struct {
    kind_e       kind;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [17:0] sram;
    logic        we;
    logic        cs;
    logic [7:0]  dout;
    logic        rom;
  } vec_t;

  vec_t vecs [32];
  int   nvec = 0;

  task automatic add(input kind_e k, input logic [15:0] a, input logic [7:0] d,
                     input logic [17:0] s, input logic we, input logic cs,
                     input logic [7:0] dout, input logic rom);
    vecs[nvec] = '{k, a, d, s, we, cs, dout, rom};
    nvec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    n_iorq = 1'b1; n_mreq = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk100);
    cpu_addr = a; cpu_dout = d;
    n_iorq = 1'b0; n_wr = 1'b0;
    repeat (12) @(negedge clk100);
    idle();
    repeat (4) @(negedge clk100);
  endtask

  task automatic start(input kind_e k, input logic [15:0] a);
    @(negedge clk100);
    cpu_addr = a;
    case (k)
      IORD:    begin n_iorq = 1'b0; n_rd = 1'b0; end
      MEMRD:   begin n_mreq = 1'b0; n_rd = 1'b0; end
      MEMWR:   begin n_mreq = 1'b0; n_wr = 1'b0; end
      default: ;
    endcase
    #1;
  endtask

  initial begin
    cpu_addr = 16'h0000; cpu_dout = 8'h00;
    idle();
    n_reset = 1'b0;
    repeat (3) @(negedge clk100);
    n_reset = 1'b1;

    // kind  addr      data   sram      we   cs   dout   rom
    add(MEMRD, 16'hC123, 8'h00, 18'h0C123, 1'b1, 1'b1, 8'h00, 1'b0);
    add(IORD,  16'h00F2, 8'h00, 18'h000F2, 1'b1, 1'b0, 8'h02, 1'b0);
    add(IORD,  16'h00F4, 8'h00, 18'h000F4, 1'b1, 1'b0, 8'h00, 1'b0);
    add(IOW,   16'h00F3, 8'h0F, 18'h0,     1'b1, 1'b1, 8'h00, 1'b0);
    add(IOW,   16'h00F4, 8'h01, 18'h0,     1'b1, 1'b1, 8'h00, 1'b0);
    add(MEMRD, 16'hC123, 8'h00, 18'h3C123, 1'b1, 1'b1, 8'h00, 1'b0);
    add(IORD,  16'h00F3, 8'h00, 18'h0,     1'b1, 1'b0, 8'h0F, 1'b0);
    add(IOW,   16'h00F1, 8'hA7, 18'h0,     1'b1, 1'b1, 8'h00, 1'b0);
    add(IORD,  16'h00F1, 8'h00, 18'h0,     1'b1, 1'b0, 8'h07, 1'b0);
    add(MEMRD, 16'h4000, 8'h00, 18'h1C000, 1'b1, 1'b1, 8'h00, 1'b0);
    add(IORD,  16'h00F4, 8'h00, 18'h0,     1'b1, 1'b0, 8'h01, 1'b0);
    add(IOW,   16'h00F5, 8'h02, 18'h0,     1'b1, 1'b1, 8'h00, 1'b0);
    add(IORD,  16'h00F5, 8'h00, 18'h0,     1'b1, 1'b0, 8'h02, 1'b0);
    add(MEMWR, 16'h4000, 8'h00, 18'h1C000, 1'b1, 1'b1, 8'h00, 1'b0);
    add(MEMWR, 16'h8000, 8'h00, 18'h08000, 1'b0, 1'b1, 8'h00, 1'b0);
    add(IORD,  16'h00F6, 8'h00, 18'h0,     1'b1, 1'b1, 8'h00, 1'b0);
    add(IORD,  16'h0038, 8'h00, 18'h0,     1'b1, 1'b1, 8'h00, 1'b0);
    add(IOW,   16'h0038, 8'h55, 18'h0,     1'b1, 1'b1, 8'h00, 1'b1);
    add(MEMRD, 16'h0100, 8'h00, 18'h00100, 1'b1, 1'b1, 8'h00, 1'b1);
    add(IOW,   16'h00F7, 8'hFF, 18'h0,     1'b1, 1'b1, 8'h00, 1'b1);
    add(IORD,  16'h00F5, 8'h00, 18'h0,     1'b1, 1'b0, 8'h02, 1'b1);
    add(IOW,   16'h00F4, 8'h00, 18'h0,     1'b1, 1'b1, 8'h00, 1'b1);
    add(MEMWR, 16'h4000, 8'h00, 18'h04000, 1'b0, 1'b1, 8'h00, 1'b1);

    for (int i = 0; i < nvec; i++) begin
      vec_t v;
      v = vecs[i];
      if (v.kind == IOW) begin
        io_write(v.addr, v.data);
        chk($sformatf("v%0d rom", i), 32'(n_rom_active), 32'(v.rom));
      end else begin
        start(v.kind, v.addr);
        chk($sformatf("v%0d cs", i), 32'(n_reg_cs), 32'(v.cs));
        chk($sformatf("v%0d dout", i), 32'(reg_dout), 32'(v.dout));
        chk($sformatf("v%0d rom", i), 32'(n_rom_active), 32'(v.rom));
        if (v.kind != IORD) begin
          chk($sformatf("v%0d sram", i), 32'(sram_addr), 32'(v.sram));
          chk($sformatf("v%0d we", i), 32'(n_sram_we), 32'(v.we));
        end
        @(negedge clk100);
        idle();
      end
    end

    // Write latency: page0 update seen through the translation of port $F0.
    io_write(16'h00F4, 8'h01);
    @(negedge clk100);
    cpu_addr = 16'h00F0; cpu_dout = 8'h05;
    n_iorq = 1'b0; n_wr = 1'b0;
    repeat (3) @(negedge clk100);
    chk("lat 3clk old", 32'(sram_addr), 32'h000F0);
    @(negedge clk100);
    chk("lat 4clk new", 32'(sram_addr), 32'h140F0);
    repeat (10) @(negedge clk100);
    idle();
    repeat (4) @(negedge clk100);

    // One-period glitch covering a single clock edge.
    cpu_addr = 16'h00F0; cpu_dout = 8'h09;
    n_iorq = 1'b0; n_wr = 1'b0;
    @(negedge clk100);
    idle();
    repeat (8) @(negedge clk100);
    // Sub-period glitch on n_wr only, with IORQ held active.
    n_iorq = 1'b0;
    #3 n_wr = 1'b0;
    #4 n_wr = 1'b1;
    @(negedge clk100);
    idle();
    repeat (8) @(negedge clk100);
    start(IORD, 16'h00F0);
    chk("glitch page0", 32'(reg_dout), 32'h05);
    @(negedge clk100);
    idle();

    // Async reset in the middle of a page write.
    @(negedge clk100);
    cpu_addr = 16'h00F2; cpu_dout = 8'h0C;
    n_iorq = 1'b0; n_wr = 1'b0;
    repeat (2) @(negedge clk100);
    #2 n_reset = 1'b0;
    #1;
    chk("rst rom", 32'(n_rom_active), 32'h0);
    chk("rst sram", 32'(sram_addr), 32'h000F2);
    repeat (3) @(negedge clk100);
    idle();
    @(negedge clk100);
    n_reset = 1'b1;
    repeat (6) @(negedge clk100);
    for (int r = 0; r < 6; r++) begin
      logic [7:0] exp_r;
      exp_r = (r < 4) ? 8'(r) : 8'h00;
      start(IORD, 16'h00F0 + 16'(r));
      chk($sformatf("rst reg%0d", r), 32'(reg_dout), 32'(exp_r));
      @(negedge clk100);
      idle();
    end
    chk("rst rom after", 32'(n_rom_active), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
